// File: rtl/fpu_fmt_pkg.sv
// Shared FP32/FP64 format constants and enums.
// Used by the widening, narrowing and compare stages.
package fpu_fmt_pkg;

    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_FRAC_W = 23;
    localparam int unsigned FP64_EXP_W  = 11;
    localparam int unsigned FP64_FRAC_W = 52;

    localparam int unsigned BIAS32    = 127;
    localparam int unsigned BIAS64    = 1023;
    localparam logic [FP64_EXP_W-1:0] BIAS_DIFF = 11'd896;

    // Exponent of a leading one at frac bit 22, before the per-shift decrement.
    localparam logic [FP64_EXP_W-1:0] DEN_EXP_BASE = 11'd897;

    localparam logic [FP32_EXP_W-1:0] EXP32_MAX = 8'hFF;
    localparam logic [FP64_EXP_W-1:0] EXP64_MAX = 11'h7FF;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } cvt_state_e;

endpackage

// File: rtl/fpu_fp32_classify.sv
// Combinational FP32 operand classifier.
module fpu_fp32_classify
    import fpu_fmt_pkg::*;
(
    input  logic [31:0] src,
    output fp_class_e   cls
);

    fp32_t op;
    assign op = src;

    always_comb begin
        cls = ZERO;
        if (op.exp == '0) begin
            cls = (op.frac == '0) ? ZERO : DENORM;
        end else if (op.exp == EXP32_MAX) begin
            if (op.frac == '0)
                cls = INF;
            else if (op.frac[FP32_FRAC_W-1])
                cls = QNAN;
            else
                cls = SNAN;
        end else begin
            cls = NORMAL;
        end
    end

endmodule

// File: rtl/fpu_fp32_to_fp64.sv
// FP32 -> FP64 widening converter; exact, with iterative denormal normalisation
// (one bit per cycle) behind a valid/ready handshake.
module fpu_fp32_to_fp64
    import fpu_fmt_pkg::*;
#(
    parameter bit DAZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] src,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] dst,
    output logic        flag_denorm,
    output logic        flag_snan
);

    cvt_state_e              state;
    logic [FP32_FRAC_W-1:0]  man;
    logic [4:0]              cnt;
    logic                    sgn;

    fp32_t                   op;
    fp_class_e               cls;
    logic                    accept;
    logic [FP64_EXP_W-1:0]   norm_exp;
    logic [FP64_EXP_W-1:0]   den_exp;

    assign op = src;

    fpu_fp32_classify u_classify (
        .src (src),
        .cls (cls)
    );

    assign req_ready = (state == IDLE) || (state == DONE && rsp_ready);
    assign accept    = req_valid && req_ready;

    assign norm_exp = {3'b000, op.exp} + BIAS_DIFF;
    // cnt+1 shifts have been applied once the leading one is found
    assign den_exp  = DEN_EXP_BASE - {6'd0, cnt} - 11'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            dst         <= '0;
            flag_denorm <= 1'b0;
            flag_snan   <= 1'b0;
            cnt         <= '0;
            man         <= '0;
            sgn         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        flag_denorm <= 1'b0;
                        flag_snan   <= 1'b0;
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        case (cls)
                            ZERO:   dst <= {op.sign, 63'd0};
                            NORMAL: dst <= {op.sign, norm_exp, op.frac, 29'd0};
                            INF:    dst <= {op.sign, EXP64_MAX, 52'd0};
                            QNAN, SNAN: begin
                                dst       <= {op.sign, EXP64_MAX, 1'b1, op.frac[21:0], 29'd0};
                                flag_snan <= ~op.frac[FP32_FRAC_W-1];
                            end
                            DENORM: begin
                                flag_denorm <= 1'b1;
                                if (DAZ) begin
                                    dst <= {op.sign, 63'd0};
                                end else begin
                                    man       <= op.frac;
                                    cnt       <= '0;
                                    sgn       <= op.sign;
                                    state     <= NORM;
                                    rsp_valid <= 1'b0;
                                end
                            end
                            default: dst <= {op.sign, 63'd0};
                        endcase
                    end else if (state == DONE && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                NORM: begin
                    man <= man << 1;
                    cnt <= cnt + 5'd1;
                    if (man[FP32_FRAC_W-1]) begin
                        dst       <= {sgn, den_exp, man[21:0], 1'b0, 29'd0};
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
